// File: rtl/reg_file_32x32.sv
// reg_file_32x32: two-read/one-write flip-flop register file feeding the
// 32-bit logic gate array. RDATA1 drives operand A, RDATA2 drives operand B,
// and gate results come back through the write port. Read data is registered
// with write-first bypass. Register 0 can optionally be hardwired to zero.
module reg_file_32x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD_EN,
    input  logic [ADDR_WIDTH-1:0] RADDR1,
    input  logic [ADDR_WIDTH-1:0] RADDR2,
    input  logic                  WR_EN,
    input  logic [ADDR_WIDTH-1:0] WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [DATA_WIDTH-1:0] RDATA2,
    output logic                  RVALID
);

    localparam int   NUM_REGS    = 2 ** ADDR_WIDTH;
    localparam logic ZERO_REG_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic                  write_ok;
    logic [DATA_WIDTH-1:0] read_next1;
    logic [DATA_WIDTH-1:0] read_next2;

    // A write to register 0 is dropped when it is hardwired to zero.
    assign write_ok = WR_EN && !(ZERO_REG_EN && (WADDR == '0));

    // Storage array: cleared by reset, updated by the write port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (write_ok) begin
            mem[WADDR] <= WDATA;
        end
    end

    // Next read values: array contents, overridden by a same-edge write
    // (bypass), overridden in turn by the zero-register rule.
    always_comb begin
        read_next1 = mem[RADDR1];
        read_next2 = mem[RADDR2];
        if (WR_EN && (WADDR == RADDR1)) begin
            read_next1 = WDATA;
        end
        if (WR_EN && (WADDR == RADDR2)) begin
            read_next2 = WDATA;
        end
        if (ZERO_REG_EN && (RADDR1 == '0)) begin
            read_next1 = '0;
        end
        if (ZERO_REG_EN && (RADDR2 == '0)) begin
            read_next2 = '0;
        end
    end

    // Registered read ports: capture on RD_EN, otherwise hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RDATA1 <= '0;
            RDATA2 <= '0;
        end else if (RD_EN) begin
            RDATA1 <= read_next1;
            RDATA2 <= read_next2;
        end
    end

    // RVALID is a one-cycle-delayed copy of RD_EN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RVALID <= 1'b0;
        end else begin
            RVALID <= RD_EN;
        end
    end

endmodule

// File: tb/tb_reg_file_32x32.sv
// tb_reg_file_32x32: drives one ZERO_REG=1 and one ZERO_REG=0 instance with the
// same directed stimulus, checks both against a write-then-read array model on
// every falling edge, and pins the model with hand-computed literal checks.
module tb_reg_file_32x32;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wr_en;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    logic [31:0] z_rdata1, z_rdata2, n_rdata1, n_rdata2;
    logic        z_rvalid, n_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut_z (
        .CLK(clk), .RST(rst), .RD_EN(rd_en), .RADDR1(raddr1), .RADDR2(raddr2),
        .WR_EN(wr_en), .WADDR(waddr), .WDATA(wdata),
        .RDATA1(z_rdata1), .RDATA2(z_rdata2), .RVALID(z_rvalid)
    );

    reg_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0)) dut_n (
        .CLK(clk), .RST(rst), .RD_EN(rd_en), .RADDR1(raddr1), .RADDR2(raddr2),
        .WR_EN(wr_en), .WADDR(waddr), .WDATA(wdata),
        .RDATA1(n_rdata1), .RDATA2(n_rdata2), .RVALID(n_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory contents plus expected outputs for both variants.
    logic [31:0] mz [32];
    logic [31:0] mn [32];
    logic [31:0] ez1 = '0, ez2 = '0, en1 = '0, en2 = '0;
    logic        ev  = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mz[i] = '0;
            mn[i] = '0;
        end
    end

    // Write-first: apply this edge's write to the model array, then read it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mz[i] = '0;
                mn[i] = '0;
            end
            ez1 = '0; ez2 = '0; en1 = '0; en2 = '0; ev = 1'b0;
        end else begin
            if (wr_en) begin
                if (waddr != 5'd0) mz[waddr] = wdata;
                mn[waddr] = wdata;
            end
            if (rd_en) begin
                ez1 = (raddr1 == 5'd0) ? 32'd0 : mz[raddr1];
                ez2 = (raddr2 == 5'd0) ? 32'd0 : mz[raddr2];
                en1 = mn[raddr1];
                en2 = mn[raddr2];
            end
            ev = rd_en;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("z_rdata1", z_rdata1, ez1);
        check("z_rdata2", z_rdata2, ez2);
        check("z_rvalid", {31'd0, z_rvalid}, {31'd0, ev});
        check("n_rdata1", n_rdata1, en1);
        check("n_rdata2", n_rdata2, en2);
        check("n_rvalid", {31'd0, n_rvalid}, {31'd0, ev});
    end

    task automatic cyc(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic w, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rd_en = r; raddr1 = a1; raddr2 = a2;
        wr_en = w; waddr = wa; wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_z_rdata1"}, z_rdata1, 32'd0);
        check({tag, "_z_rdata2"}, z_rdata2, 32'd0);
        check({tag, "_z_rvalid"}, {31'd0, z_rvalid}, 32'd0);
        check({tag, "_n_rdata1"}, n_rdata1, 32'd0);
        check({tag, "_n_rvalid"}, {31'd0, n_rvalid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        rd_en = 1'b0; raddr1 = '0; raddr2 = '0;
        wr_en = 1'b0; waddr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset: fill every register, read one back, then reset mid-cycle.
        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'(i), 32'hFFFF_FFFF);
        cyc(1'b1, 5'd5, 5'd9, 1'b0, 5'd0, 32'd0);
        check("fill_rd_r5", z_rdata1, 32'hFFFF_FFFF);
        check("fill_rvalid", {31'd0, z_rvalid}, 32'd1);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #2 rst = 1'b1;
        #1 check_cleared("rst_async");
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 5'(32 - i), 1'b0, 5'd0, 32'd0);
        check("post_rst_r31", z_rdata1, 32'd0);
        check("post_rst_n_r1", n_rdata2, 32'd0);

        // Write then read same register on both ports.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 32'hA5A5_5A5A);
        cyc(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
        check("wr_rd_r7_p1", z_rdata1, 32'hA5A5_5A5A);
        check("wr_rd_r7_p2", z_rdata2, 32'hA5A5_5A5A);
        check("wr_rd_rvalid", {31'd0, z_rvalid}, 32'd1);
        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        check("rvalid_one_cycle", {31'd0, z_rvalid}, 32'd0);
        check("hold_after_read", z_rdata1, 32'hA5A5_5A5A);

        // Bypass on port 1, plain read on port 2.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_1111);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h4444_0004);
        cyc(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 32'hDEAD_BEEF);
        check("bypass_p1", z_rdata1, 32'hDEAD_BEEF);
        check("bypass_p2", z_rdata2, 32'h4444_0004);
        cyc(1'b1, 5'd4, 5'd3, 1'b0, 5'd0, 32'd0);
        check("bypass_landed", z_rdata2, 32'hDEAD_BEEF);

        // Register 0: hardwired vs ordinary, including a bypass attempt.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234_5678);
        cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        check("zr1_r0_p1", z_rdata1, 32'd0);
        check("zr1_r0_p2", z_rdata2, 32'd0);
        check("zr0_r0_p1", n_rdata1, 32'h1234_5678);
        check("zr0_r0_p2", n_rdata2, 32'h1234_5678);
        cyc(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 32'h0BAD_F00D);
        check("zr1_bypass_r0", z_rdata1, 32'd0);
        check("zr0_bypass_r0", n_rdata2, 32'h0BAD_F00D);

        // Streaming reads, then hold with writes and no reads.
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd1, 32'h0000_0011);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd2, 32'h0000_0022);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h0000_0033);
        cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h0000_0044);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 5'(i), 5'(5 - i), 1'b0, 5'd0, 32'd0);
            check("stream_p1", z_rdata1, 32'(i * 17));
            check("stream_p2", z_rdata2, 32'((5 - i) * 17));
            check("stream_rvalid", {31'd0, z_rvalid}, 32'd1);
        end
        cyc(1'b0, 5'd1, 5'd1, 1'b1, 5'd1, 32'h9999_9999);
        cyc(1'b0, 5'd1, 5'd1, 1'b1, 5'd1, 32'h7777_7777);
        check("hold_p1", z_rdata1, 32'h0000_0044);
        check("hold_p2", z_rdata2, 32'h0000_0011);
        check("hold_rvalid", {31'd0, z_rvalid}, 32'd0);

        // Reset during a read/write burst: pending write to r5 must not land.
        cyc(1'b1, 5'd1, 5'd2, 1'b1, 5'd6, 32'h6666_6666);
        cyc(1'b1, 5'd6, 5'd1, 1'b1, 5'd7, 32'h7070_7070);
        @(negedge clk);
        rd_en = 1'b1; raddr1 = 5'd6; raddr2 = 5'd7;
        wr_en = 1'b1; waddr = 5'd5; wdata = 32'h5555_5555;
        #2 rst = 1'b1;
        #1 check_cleared("rst_burst");
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
        #2 rst = 1'b0;
        cyc(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 32'd0);
        check("r5_not_landed_z", z_rdata1, 32'd0);
        check("r5_not_landed_n", n_rdata1, 32'd0);
        check("r6_cleared", n_rdata2, 32'd0);
        check("post_burst_rvalid", {31'd0, n_rvalid}, 32'd1);

        cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
